// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module   : regfile_scoreboard
// Summary  : Per-register outstanding-write scoreboard that gates decode
//            issue on RAW hazards and destination-counter room.
//            Optional macro SCOREBOARD_BYPASS_EN lets a same-cycle writeback
//            release a source (and free a destination slot) immediately.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int ID_W     = 4,
    parameter int CNT_W    = 2,
    parameter int STALL_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [ID_W-1:0]     issue_rs,
    input  logic                issue_rs_en,
    input  logic [ID_W-1:0]     issue_rt,
    input  logic                issue_rt_en,
    input  logic [ID_W-1:0]     issue_rd,
    input  logic                issue_rd_en,
    input  logic                wb_valid,
    input  logic [ID_W-1:0]     wb_rd,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [STALL_W-1:0]  stall_cnt,
    output logic                wb_err
);

    localparam logic [CNT_W-1:0]   c_cnt_max   = '1;
    localparam logic [CNT_W-1:0]   c_cnt_one   = CNT_W'(1);
    localparam logic [STALL_W-1:0] c_stall_max = '1;

    logic [CNT_W-1:0]    w_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] w_busy;
    logic [NUM_REGS-1:0] w_src_busy;
    logic [NUM_REGS-1:0] w_full;
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;
    logic                w_fire;
    logic                w_wb_orphan;

    logic [STALL_W-1:0]  r_stall_cnt;
    logic                r_wb_err;

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
            if (g == 0) begin : g_zero
                // R0 is hardwired zero and never participates in hazards.
                assign w_cnt[g]      = '0;
                assign w_busy[g]     = 1'b0;
                assign w_src_busy[g] = 1'b0;
                assign w_full[g]     = 1'b0;
                assign w_inc[g]      = 1'b0;
                assign w_dec[g]      = 1'b0;
            end else begin : g_track
                logic [CNT_W-1:0] r_cnt;

                assign w_inc[g]  = w_fire & issue_rd_en & (issue_rd == ID_W'(g));
                assign w_dec[g]  = wb_valid & (wb_rd == ID_W'(g)) & (r_cnt != '0);
                assign w_cnt[g]  = r_cnt;
                assign w_busy[g] = (r_cnt != '0);

`ifdef SCOREBOARD_BYPASS_EN
                // Last pending write retiring now: the regfile bypass covers the read.
                assign w_src_busy[g] = w_busy[g] & ~(w_dec[g] & (r_cnt == c_cnt_one));
                assign w_full[g]     = (r_cnt == c_cnt_max) & ~w_dec[g];
`else
                assign w_src_busy[g] = w_busy[g];
                assign w_full[g]     = (r_cnt == c_cnt_max);
`endif

                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_cnt <= '0;
                    end else if (flush) begin
                        r_cnt <= '0;
                    end else if (w_inc[g] && !w_dec[g]) begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end else if (!w_inc[g] && w_dec[g]) begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
            end
        end
    endgenerate

    assign issue_ready = ~(issue_rs_en & w_src_busy[issue_rs])
                       & ~(issue_rt_en & w_src_busy[issue_rt])
                       & ~(issue_rd_en & w_full[issue_rd]);

    assign w_fire      = issue_valid & issue_ready;
    assign w_wb_orphan = wb_valid & (wb_rd != '0) & (w_cnt[wb_rd] == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (issue_valid && !issue_ready && !flush && (r_stall_cnt != c_stall_max)) begin
            r_stall_cnt <= r_stall_cnt + STALL_W'(1);
        end
    end

    // A flushed cycle's writeback is discarded, so it cannot raise the error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_err <= 1'b0;
        end else if (!flush && w_wb_orphan) begin
            r_wb_err <= 1'b1;
        end
    end

    assign busy_vec  = w_busy;
    assign stall_cnt = r_stall_cnt;
    assign wb_err    = r_wb_err;

endmodule

`default_nettype wire
